// File: rtl/alu_result_serializer.sv
// rtl/alu_result_serializer.sv - buffers ALU results in a 2-entry FIFO and streams them as LSB/MSB bytes
module alu_result_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    i_CLK,
  input  logic                    i_RST,
  input  logic [2*DATA_WIDTH-1:0] i_ALU_OUT,
  input  logic                    i_OUT_Valid,
  input  logic                    i_TX_Ready,
  output logic [DATA_WIDTH-1:0]   o_TX_DATA,
  output logic                    o_TX_Valid,
  output logic                    o_Full,
  output logic                    o_Overflow
);

  typedef enum logic [1:0] {IDLE, SEND_LSB, SEND_MSB} state_t;

  state_t                  state_q, state_d;
  logic [2*DATA_WIDTH-1:0] mem_q [2];
  logic                    wr_ptr_q, rd_ptr_q;
  logic [1:0]              count_q, count_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic                    tx_valid_q, tx_valid_d;
  logic                    full_q, ovf_q, ovf_d;
  logic                    push, pop;
  logic [2*DATA_WIDTH-1:0] head, head_next;

  assign head = mem_q[rd_ptr_q];
  assign pop  = (state_q == SEND_MSB) && i_TX_Ready;
  assign push = i_OUT_Valid && ((count_q != 2'd2) || pop);
  assign ovf_d = ovf_q | (i_OUT_Valid && !push);
  assign count_d = count_q + {1'b0, push} - {1'b0, pop};
  // With only one entry left, the word replacing the popped head is the one arriving this cycle.
  assign head_next = (count_q == 2'd2) ? mem_q[~rd_ptr_q] : i_ALU_OUT;

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (count_q != 2'd0) state_d = SEND_LSB;
      SEND_LSB: if (i_TX_Ready) state_d = SEND_MSB;
      SEND_MSB: if (i_TX_Ready) state_d = (count_d != 2'd0) ? SEND_LSB : IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    case (state_q)
      IDLE: begin
        tx_valid_d = 1'b0;
        if (count_q != 2'd0) begin
          tx_data_d  = head[DATA_WIDTH-1:0];
          tx_valid_d = 1'b1;
        end
      end
      SEND_LSB: begin
        if (i_TX_Ready) tx_data_d = head[2*DATA_WIDTH-1:DATA_WIDTH];
      end
      SEND_MSB: begin
        if (i_TX_Ready) begin
          if (count_d != 2'd0) begin
            tx_data_d  = head_next[DATA_WIDTH-1:0];
            tx_valid_d = 1'b1;
          end else begin
            tx_valid_d = 1'b0;
          end
        end
      end
      default: tx_valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= i_ALU_OUT;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q    <= count_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      full_q     <= (count_d == 2'd2);
      ovf_q      <= ovf_d;
    end
  end

  assign o_TX_DATA  = tx_data_q;
  assign o_TX_Valid = tx_valid_q;
  assign o_Full     = full_q;
  assign o_Overflow = ovf_q;

endmodule

// File: tb/tb_alu_result_serializer.sv
// tb/tb_alu_result_serializer.sv - directed bench with a queue-based reference model
module tb_alu_result_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] alu_out = '0;
  logic        out_valid = 1'b0;
  logic        tx_ready = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid, full, ovf;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_q[$];
  logic        m_valid, m_full, m_ovf;
  logic [7:0]  m_data;
  bit          m_byte;

  logic [7:0]  got[$];
  logic [7:0]  exp_q[$];

  alu_result_serializer #(.DATA_WIDTH(8)) dut (
    .i_CLK(clk), .i_RST(rst_n), .i_ALU_OUT(alu_out), .i_OUT_Valid(out_valid),
    .i_TX_Ready(tx_ready), .o_TX_DATA(tx_data), .o_TX_Valid(tx_valid),
    .o_Full(full), .o_Overflow(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_valid = 1'b0; m_full = 1'b0; m_ovf = 1'b0; m_data = '0; m_byte = 1'b0;
  endtask

  // The link sends the head word low byte then high byte; the word leaves the queue once its high byte goes.
  task automatic model_step(input bit v, input logic [15:0] w, input bit rdy);
    int          pre;
    bit          acc, popped;
    logic [15:0] h;
    logic        nv;
    logic [7:0]  nd;
    bit          nb;
    pre = m_q.size();
    acc = m_valid && rdy;
    popped = acc && m_byte;
    nv = m_valid; nd = m_data; nb = m_byte;
    if (acc && !m_byte) begin
      h = m_q[0]; nb = 1'b1; nd = h[15:8];
    end
    if (popped) void'(m_q.pop_front());
    if (v) begin
      if (pre < 2 || popped) m_q.push_back(w);
      else m_ovf = 1'b1;
    end
    if (popped) begin
      if (m_q.size() > 0) begin
        h = m_q[0]; nv = 1'b1; nb = 1'b0; nd = h[7:0];
      end else begin
        nv = 1'b0;
      end
    end
    if (!m_valid && pre > 0) begin
      h = m_q[0]; nv = 1'b1; nb = 1'b0; nd = h[7:0];
    end
    m_valid = nv; m_data = nd; m_byte = nb;
    m_full = (m_q.size() == 2);
  endtask

  task automatic compare();
    chk("tx_valid", {31'd0, tx_valid}, {31'd0, m_valid});
    if (m_valid) chk("tx_data", {24'd0, tx_data}, {24'd0, m_data});
    chk("full", {31'd0, full}, {31'd0, m_full});
    chk("overflow", {31'd0, ovf}, {31'd0, m_ovf});
  endtask

  task automatic cycle(input bit v, input logic [15:0] w, input bit rdy);
    out_valid = v; alu_out = w; tx_ready = rdy;
    if (tx_valid && rdy) got.push_back(tx_data);
    @(posedge clk);
    model_step(v, w, rdy);
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, rdy);
  endtask

  task automatic check_got(input string name);
    chk({name, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_byte%0d", name, i), {24'd0, got[i]}, {24'd0, exp_q[i]});
    got.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; out_valid = 1'b0; tx_ready = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    got.delete();
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_data", {24'd0, tx_data}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    rst_n = 1'b1;
    idle(2, 1'b1);

    cycle(1'b1, 16'hA55A, 1'b1);
    chk("single_lat_edge1", {31'd0, tx_valid}, 32'd0);
    idle(1, 1'b1);
    chk("single_lat_valid", {31'd0, tx_valid}, 32'd1);
    chk("single_lat_data", {24'd0, tx_data}, 32'h5A);
    idle(4, 1'b1);
    exp_q = {8'h5A, 8'hA5};
    check_got("single");

    cycle(1'b1, 16'h1234, 1'b0);
    idle(6, 1'b0);
    chk("bp_hold", {24'd0, tx_data}, 32'h34);
    idle(4, 1'b1);
    exp_q = {8'h34, 8'h12};
    check_got("backpressure");

    cycle(1'b1, 16'h0102, 1'b1);
    cycle(1'b1, 16'h0304, 1'b1);
    chk("b2b_full", {31'd0, full}, 32'd1);
    idle(7, 1'b1);
    exp_q = {8'h02, 8'h01, 8'h04, 8'h03};
    check_got("back2back");

    cycle(1'b1, 16'hAAAA, 1'b0);
    cycle(1'b1, 16'hBBBB, 1'b0);
    cycle(1'b0, 16'h0, 1'b1);
    cycle(1'b1, 16'hCCCC, 1'b1);
    chk("simul_full", {31'd0, full}, 32'd1);
    chk("simul_ovf", {31'd0, ovf}, 32'd0);
    idle(8, 1'b1);
    exp_q = {8'hAA, 8'hAA, 8'hBB, 8'hBB, 8'hCC, 8'hCC};
    check_got("simul");

    cycle(1'b1, 16'h1111, 1'b0);
    cycle(1'b1, 16'h2222, 1'b0);
    chk("ovf_full2", {31'd0, full}, 32'd1);
    cycle(1'b1, 16'h3333, 1'b0);
    chk("ovf_set", {31'd0, ovf}, 32'd1);
    idle(8, 1'b1);
    exp_q = {8'h11, 8'h11, 8'h22, 8'h22};
    check_got("overflow");
    chk("ovf_sticky", {31'd0, ovf}, 32'd1);

    do_reset();
    cycle(1'b1, 16'hBEEF, 1'b0);
    idle(1, 1'b0);
    idle(1, 1'b1);
    chk("mid_msb_data", {24'd0, tx_data}, 32'hBE);
    tx_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", {31'd0, tx_valid}, 32'd0);
    chk("async_data", {24'd0, tx_data}, 32'd0);
    chk("async_full", {31'd0, full}, 32'd0);
    chk("async_ovf", {31'd0, ovf}, 32'd0);
    model_reset();
    got.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(4, 1'b1);
    chk("post_rst_idle", {31'd0, tx_valid}, 32'd0);
    exp_q.delete();
    check_got("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_result_serializer.md
# alu_result_serializer

Downstream consumer of the ALU result port. Captures each 2*DATA_WIDTH-bit result qualified by the ALU valid strobe into a 2-entry FIFO. Splits each result into two DATA_WIDTH-bit bytes, LSB first. Hands the bytes to the UART transmit path over a valid/ready handshake, so results produced faster than the serial link can drain them are buffered rather than lost.

## Interface
Parameters:
- DATA_WIDTH, 8, byte width; the result input is 2*DATA_WIDTH bits wide.

Ports:
- i_CLK  in  1  single system clock; all state updates on the rising edge.
- i_RST  in  1  asynchronous, active-low reset.
- i_ALU_OUT  in  2*DATA_WIDTH  ALU result word.
- i_OUT_Valid  in  1  result qualifier. Every cycle it is high is one distinct result.
- i_TX_Ready  in  1  transmit path accepts o_TX_DATA this cycle.
- o_TX_DATA  out  DATA_WIDTH  byte to transmit; registered.
- o_TX_Valid  out  1  o_TX_DATA is valid; registered.
- o_Full  out  1  FIFO holds 2 entries; registered. Upstream controller stalls new ALU commands on it.
- o_Overflow  out  1  sticky; a result was dropped; registered.

## Operation
- Reset (i_RST low, asynchronous): all outputs 0, FIFO count 0, read/write pointers 0, state IDLE. Applies immediately, including mid-transfer; a half-sent result is discarded.
- FIFO behaviour:
  - 2 entries of 2*DATA_WIDTH bits, 1-bit read/write pointers, 2-bit count.
  - Push when i_OUT_Valid=1 and (count<2 or a pop occurs the same cycle).
  - Pop occurs on MSB acceptance (see below).
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Push with count=2 and no pop that cycle: the word is discarded, o_Overflow set to 1. It stays set until reset.
- States: IDLE, SEND_LSB, SEND_MSB.
  - IDLE: o_TX_Valid=0. If count>0, move to SEND_LSB. On the same edge load o_TX_DATA=head[DATA_WIDTH-1:0] and o_TX_Valid=1.
  - SEND_LSB: hold o_TX_DATA/o_TX_Valid stable until i_TX_Ready=1. On acceptance, move to SEND_MSB and load o_TX_DATA=head[2*DATA_WIDTH-1:DATA_WIDTH]. o_TX_Valid stays 1.
  - SEND_MSB: hold until i_TX_Ready=1. On acceptance, pop the head.
    - If at least one entry remains after pop/push accounting (count_next>0), go to SEND_LSB with the new head LSB loaded. o_TX_Valid stays 1, with no bubble.
    - Else go to IDLE, o_TX_Valid=0.
- Handshake: a byte transfers on a rising edge where o_TX_Valid=1 and i_TX_Ready=1. o_TX_DATA never changes while o_TX_Valid=1 and i_TX_Ready=0. i_TX_Ready while o_TX_Valid=0 is ignored.
- A push into an empty FIFO with the state already IDLE is seen by IDLE on the following cycle. There is no combinational bypass.
- o_Full = (count_next==2), registered.

## Timing
- Input capture: a result with i_OUT_Valid high at edge k is written at edge k.
- First byte: o_TX_Valid rises after edge k+1 when the FIFO was empty and the state was IDLE. Latency is 2 edges from valid to first byte presented.
- Each byte takes at least 1 cycle. A result needs at least 2 cycles with i_TX_Ready held high.
- Back-to-back results drain at 1 byte per cycle with no idle cycle between results.
- o_Full asserts on the same edge as the second push. It deasserts on the edge of the pop that frees a slot.
- Sustained i_OUT_Valid faster than 1 result per 2 cycles eventually overflows. That is legal, and detection is the job of o_Overflow.

## Test plan
- Reset: drive i_RST low mid-SEND_MSB with i_TX_Ready=0 -> all outputs 0 immediately, asynchronously. After release with no input, o_TX_Valid stays 0.
- Single result: i_OUT_Valid pulse with i_ALU_OUT=16'hA55A, i_TX_Ready=1 -> o_TX_DATA=8'h5A with o_TX_Valid high 2 edges after capture, then 8'hA5 the next cycle, then o_TX_Valid=0.
- Backpressure: result 16'h1234 with i_TX_Ready=0 for 5 cycles, then 1 -> 8'h34 held stable for all 5 stalled cycles, then 8'h12 for 1 cycle, then idle.
- Back-to-back: results 16'h0102 and 16'h0304 on consecutive cycles, i_TX_Ready=1 -> bytes 02,01,04,03 on 4 consecutive cycles. o_Full high for exactly the cycles when count=2.
- Overflow: i_TX_Ready=0, 3 consecutive valid results 16'h1111, 16'h2222, 16'h3333 -> o_Full=1 after the second. o_Overflow=1 after the third. Draining outputs 11,11,22,22 only, and o_Overflow stays 1.
- Simultaneous push/pop: count=2, a push arrives on the MSB-acceptance edge -> no overflow, count stays 2, and the new word is sent after the remaining entry in order.
